mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single-port unified memory between the RV32I core's instruction-fetch path and its load/store path. It replaces the separate instruction and data memories with one memory port. Each requester gets a request/acknowledge handshake, and the core stalls on a missing ack. Data accesses have priority, and a streak limit prevents fetch starvation.

## Interface
- `ADDR_W`, 32, address width (matches `ADDR_SIZE`)
- `DATA_W`, 32, data width (matches `WORD_LEN`)
- `MEM_LAT`, 2, memory read latency in cycles; legal range ≥1
- `STREAK_MAX`, 4, maximum consecutive data grants while a fetch waits; legal range ≥1
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req` is high
- `if_ack`  out  1  one-cycle pulse; `if_rdata` is valid in the same cycle
- `if_rdata`  out  DATA_W  fetched instruction
- `d_req`  in  1  data request; held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_ack`  out  1  one-cycle completion pulse
- `d_rdata`  out  DATA_W  load data; valid with `d_ack` when `d_we` was 0
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable; only meaningful when `mem_en` is high
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data; valid `MEM_LAT` cycles after the `mem_en` cycle
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Requests are sampled only in this state.
  - If any request is high, select a winner and latch owner, `we`, addr, and wdata from the winner. Go to ISSUE.
  - If no request is high, stay in IDLE.
- ISSUE:
  - Assert `mem_en` for exactly one cycle, with the latched `mem_we`, `mem_addr`, and `mem_wdata`.
  - For a write, go to ACK.
  - For a read, load the latency counter with `MEM_LAT`-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture `mem_rdata` into the owner's rdata register and go to ACK.
- ACK:
  - Pulse the owner's ack for one cycle, then go to IDLE.
  - The requester must deassert or retarget its request on the edge that ends the ack cycle.
  - A request still high in the following IDLE cycle is treated as a new request.
- Arbitration:
  - `d_req` wins over `if_req`.
  - Exception: when `streak` == `STREAK_MAX` and `if_req` is high, fetch wins.
- Streak counter:
  - Increments on a data grant made while `if_req` is high, saturating at `STREAK_MAX`.
  - Clears on any fetch grant.
  - Clears on a data grant made while `if_req` is low.
- Outputs:
  - `mem_we`, `mem_addr`, and `mem_wdata` hold their latched values outside ISSUE.
  - `if_rdata` and `d_rdata` hold their last captured value until the next capture for that owner.
  - Stores never modify `d_rdata`.
- A request that deasserts before its ack is a protocol violation; behaviour is undefined and is not checked.

## Timing
- Read request seen in IDLE at cycle 0:
  - cycle 1: ISSUE (`mem_en`=1)
  - cycles 2..MEM_LAT+1: WAIT
  - cycle MEM_LAT+2: ack
- Write request seen in IDLE at cycle 0: ISSUE in cycle 1, ack in cycle 2.
- Back-to-back read throughput: one access per MEM_LAT+3 cycles.
- Both requests high in the same IDLE cycle: only one is granted. The loser is granted in the next IDLE cycle, provided its request is still high.
- Reset values: state IDLE, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `if_ack`=0, `d_ack`=0, `if_rdata`=0, `d_rdata`=0, `streak`=0, `busy`=0.
- Reset mid-operation: the access is abandoned and no ack is issued. Late `mem_rdata` is ignored. First grant is possible in the cycle after `rst` deasserts.

## Structure
- The shared package holds:
  - the state encoding (IDLE, ISSUE, WAIT, ACK; 2 bits)
  - owner encoding (`OWNER_IF`=0, `OWNER_D`=1)
- Natural sub-module: `mem_arb_policy`. It takes `if_req`, `d_req`, and `streak`, and returns the combinational winner plus next-streak logic. It is tested separately from the FSM.
- The latency counter width is $clog2(MEM_LAT)+1.

## Test plan
- Single read: `if_req`=1, `if_addr`=0x100, `mem_rdata`=0xDEADBEEF with `MEM_LAT`=2. Expect `mem_en` in cycle 1 with `mem_addr`=0x100, `mem_we`=0. Expect `if_ack`=1 in cycle 4 with `if_rdata`=0xDEADBEEF, and `busy` high in cycles 1–4.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x40, `d_wdata`=0x12345678. Expect `mem_en`=`mem_we`=1 in cycle 1 with those values, `d_ack` in cycle 2, and `d_rdata` unchanged.
- Simultaneous requests: `if_req` and `d_req` both high at cycle 0 and held. Expect the data access to be acked first, then the fetch granted in the following IDLE cycle.
- Starvation guard: `STREAK_MAX`=4, with `d_req` and `if_req` held high and the data requester re-requesting after every ack. Expect grants D,D,D,D,IF,D,…
- Reset mid-read: assert `rst` in the WAIT cycle. Expect no `if_ack`, all outputs at their reset values the next cycle, and a new request served normally afterwards.
- `MEM_LAT`=1 build: a read ack arrives in cycle 3 and the capture happens in the first WAIT cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  // Which requester owns the access in flight
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their one-cycle ack.
// Ports: slave = arbiter view, master = core/memory (environment) view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  // load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  // single memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb_policy.sv
// Combinational winner selection and next-streak value for the arbiter.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when a grant is actually taken.
// Ports: if_req_i/d_req_i requests, streak_i current streak,
//        grant_vld_o/grant_owner_o winner, streak_nxt_o streak after this grant.
module mem_arb_policy
  import mem_port_arbiter_pkg::*;
#(
  parameter int STREAK_MAX = 4,
  parameter int STREAK_W   = $clog2(STREAK_MAX + 1)
) (
  input  logic                if_req_i,
  input  logic                d_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                grant_vld_o,
  output owner_e              grant_owner_o,
  output logic [STREAK_W-1:0] streak_nxt_o
);

  logic streak_full;
  logic fetch_wins;

  assign streak_full = (streak_i == STREAK_W'(STREAK_MAX));
  // Data normally wins; a waiting fetch overrides once data has had its run.
  assign fetch_wins  = if_req_i && (!d_req_i || streak_full);

  assign grant_vld_o   = if_req_i || d_req_i;
  assign grant_owner_o = fetch_wins ? OWNER_IF : OWNER_D;

  always_comb begin
    streak_nxt_o = streak_i;
    if (grant_vld_o) begin
      if (fetch_wins || !if_req_i) begin
        // fetch served, or nobody was starving: the streak restarts
        streak_nxt_o = '0;
      end else if (!streak_full) begin
        streak_nxt_o = streak_i + STREAK_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Latency: read ack MEM_LAT+2 cycles after the request is sampled, write ack 2.
// Backpressure: a requester stalls (holds req) until its one-cycle ack.
// Ports: clk, rst (sync, active high); bus = fetch, data and memory signals.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int CNT_W    = $clog2(MEM_LAT) + 1;
  localparam int STREAK_W = $clog2(STREAK_MAX + 1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                grant_vld;
  owner_e              grant_owner;
  logic [STREAK_W-1:0] streak_nxt;

  mem_arb_policy #(
    .STREAK_MAX (STREAK_MAX),
    .STREAK_W   (STREAK_W)
  ) u_policy (
    .if_req_i      (bus.if_req),
    .d_req_i       (bus.d_req),
    .streak_i      (streak_q),
    .grant_vld_o   (grant_vld),
    .grant_owner_o (grant_owner),
    .streak_nxt_o  (streak_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d  = grant_owner;
          streak_d = streak_nxt;
          state_d  = ISSUE;
          if (grant_owner == OWNER_D) begin
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
          end else begin
            // fetches never write; last write data is simply held
            we_d   = 1'b0;
            addr_d = bus.if_addr;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = ACK;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWNER_D) d_rdata_d  = bus.mem_rdata;
          else                    if_rdata_d = bus.mem_rdata;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = (state_q == ACK) && (owner_q == OWNER_IF);
  assign bus.d_ack     = (state_q == ACK) && (owner_q == OWNER_D);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: ack-ordered scoreboard plus cycle-exact checks.
// Latency: n/a.
// Backpressure: requesters modelled as hold-until-ack.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STREAK_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STREAK_MAX(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // memory contents as a function of address
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // memory models: data valid exactly MEM_LAT cycles after the mem_en cycle
  logic        v0_a, v0_b, v1_a;
  logic [31:0] p0_a, p0_b, p1_a;
  always @(posedge clk) begin
    v0_a <= bus.mem_en && !bus.mem_we;
    p0_a <= mem_f(bus.mem_addr);
    v0_b <= v0_a;
    p0_b <= p0_a;
    v1_a <= bus1.mem_en && !bus1.mem_we;
    p1_a <= mem_f(bus1.mem_addr);
  end
  assign bus.mem_rdata  = v0_b ? p0_b : 32'hBAD0BAD0;
  assign bus1.mem_rdata = v1_a ? p1_a : 32'hBAD0BAD0;

  // scoreboard of expected acks, in order
  typedef struct {
    logic        owner;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic push_exp(input logic owner, input logic [31:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.if_ack && bus.d_ack) begin
      check("both_ack", 1, 0);
    end else if (bus.if_ack || bus.d_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_owner", bus.d_ack, mon_e.owner);
        check("ack_data", bus.d_ack ? bus.d_rdata : bus.if_rdata, mon_e.data);
      end
    end
  end

  task automatic wait_ack(output logic is_d, output int cyc);
    is_d = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.if_ack || bus.d_ack) begin
        is_d = bus.d_ack;
        cyc  = i;
        return;
      end
    end
    check("ack_timeout", 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_en"}, bus.mem_en, 0);
    check({tag, "_we"}, bus.mem_we, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
    check({tag, "_acks"}, {bus.if_ack, bus.d_ack}, 0);
    check({tag, "_if_rdata"}, bus.if_rdata, 0);
    check({tag, "_d_rdata"}, bus.d_rdata, 0);
  endtask

  initial begin
    logic is_d;
    int   cyc;
    int   dn;
    int   fn;
    bus.if_req = 0;  bus.if_addr = 0;
    bus.d_req = 0;   bus.d_we = 0;  bus.d_addr = 0;  bus.d_wdata = 0;
    bus1.if_req = 0; bus1.if_addr = 0;
    bus1.d_req = 0;  bus1.d_we = 0; bus1.d_addr = 0; bus1.d_wdata = 0;

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 0;
    @(negedge clk);

    // single fetch read, MEM_LAT=2
    bus.if_req = 1; bus.if_addr = 32'h100;
    push_exp(1'b0, 32'hDEADBEEF);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("rd_busy", bus.busy, 1);
      check("rd_en", bus.mem_en, c == 1);
      if (c == 1) begin
        check("rd_addr", bus.mem_addr, 32'h100);
        check("rd_we", bus.mem_we, 0);
      end
      check("rd_if_ack", bus.if_ack, c == 4);
    end
    bus.if_req = 0;
    @(negedge clk);
    check("rd_idle", bus.busy, 0);

    // simultaneous requests: data load first, fetch in the next IDLE
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.d_req = 1;  bus.d_we = 0; bus.d_addr = 32'h80;
    push_exp(1'b1, mem_f(32'h80));
    push_exp(1'b0, mem_f(32'h104));
    wait_ack(is_d, cyc);
    check("sim_first_is_d", is_d, 1);
    check("sim_first_cyc", cyc, 4);
    bus.d_req = 0;
    @(negedge clk);
    check("sim_gap_idle", bus.busy, 0);
    @(negedge clk);
    check("sim_if_en", bus.mem_en, 1);
    check("sim_if_addr", bus.mem_addr, 32'h104);
    wait_ack(is_d, cyc);
    check("sim_second_is_if", is_d, 0);
    bus.if_req = 0;
    @(negedge clk);

    // store: ISSUE then ack, load data register untouched
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h12345678;
    push_exp(1'b1, mem_f(32'h80));
    @(negedge clk);
    check("st_en", bus.mem_en, 1);
    check("st_we", bus.mem_we, 1);
    check("st_addr", bus.mem_addr, 32'h40);
    check("st_wdata", bus.mem_wdata, 32'h12345678);
    @(negedge clk);
    check("st_d_ack", bus.d_ack, 1);
    bus.d_req = 0; bus.d_we = 0;
    @(negedge clk);
    check("st_d_rdata_kept", bus.d_rdata, mem_f(32'h80));
    check("st_we_held", bus.mem_we, 1);

    // starvation guard: expect D,D,D,D,IF repeating
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    dn = 0; fn = 0;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        push_exp(1'b0, mem_f(32'h300 + 32'(4 * fn)));
        fn++;
      end else begin
        push_exp(1'b1, mem_f(32'h200 + 32'(4 * dn)));
        dn++;
      end
    end
    bus.d_addr = 32'h200; bus.if_addr = 32'h300;
    bus.d_req = 1; bus.if_req = 1;
    for (int k = 0; k < 10; k++) begin
      wait_ack(is_d, cyc);
      if (is_d) bus.d_addr = bus.d_addr + 32'd4;
      else      bus.if_addr = bus.if_addr + 32'd4;
    end
    bus.d_req = 0; bus.if_req = 0;
    @(negedge clk);

    // reset asserted in the WAIT cycle of a fetch read
    bus.if_req = 1; bus.if_addr = 32'h108;
    @(negedge clk);
    check("rst_issue", bus.mem_en, 1);
    @(negedge clk);
    check("rst_in_wait", bus.busy, 1);
    rst = 1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    rst = 0;
    bus.if_addr = 32'h10C;
    push_exp(1'b0, mem_f(32'h10C));
    @(negedge clk);
    check("rst_regrant_en", bus.mem_en, 1);
    check("rst_regrant_addr", bus.mem_addr, 32'h10C);
    wait_ack(is_d, cyc);
    check("rst_regrant_is_if", is_d, 0);
    check("rst_regrant_cyc", cyc, 3);
    bus.if_req = 0;

    // MEM_LAT=1 instance: capture in first WAIT, ack in cycle 3
    @(negedge clk);
    bus1.if_req = 1; bus1.if_addr = 32'h200;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("l1_en", bus1.mem_en, c == 1);
      check("l1_busy", bus1.busy, 1);
      check("l1_ack", bus1.if_ack, c == 3);
      if (c == 3) check("l1_rdata", bus1.if_rdata, mem_f(32'h200));
    end
    bus1.if_req = 0;
    @(negedge clk);
    check("l1_idle", bus1.busy, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
